// File: rtl/dcache_pkg.sv
// Shared types and default-geometry widths for the set-associative data cache.
// Also holds the 4-way tree-PLRU helpers used by dcache_sa_top.
package dcache_pkg;

    localparam int ADDR_W_MAX = 32;
    localparam int OFFSET_W   = $clog2(256 / 8);
    localparam int INDEX_W    = $clog2(32);
    localparam int TAG_W      = ADDR_W_MAX - OFFSET_W - INDEX_W;
    localparam int WSEL_W     = $clog2(256 / 32);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_e;

    // Tag field is sized for the widest address so any geometry fits; unused upper bits stay zero.
    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [ADDR_W_MAX-1:0] tag;
    } tag_entry_t;

    function automatic logic [1:0] plru4_victim(input logic [2:0] bits);
        return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    endfunction

    function automatic logic [2:0] plru4_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] nb;
        nb    = bits;
        nb[0] = ~way[1];
        if (!way[1]) nb[1] = ~way[0];
        else         nb[2] = ~way[0];
        return nb;
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of data storage: SETS lines, combinational read, synchronous line fill or word merge.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int SETS   = 32,
    parameter int LINE_W = 256,
    parameter int WORD_W = 32
) (
    input  logic                              clk_i,
    input  logic [$clog2(SETS)-1:0]           rd_idx_i,
    output logic [LINE_W-1:0]                 rd_line_o,
    input  logic [$clog2(SETS)-1:0]           wr_idx_i,
    input  logic                              fill_en_i,
    input  logic [LINE_W-1:0]                 fill_line_i,
    input  logic                              merge_en_i,
    input  logic [$clog2(LINE_W/WORD_W)-1:0]  merge_wsel_i,
    input  logic [WORD_W-1:0]                 merge_word_i
);

    logic [LINE_W-1:0] mem_q [SETS];

    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            mem_q[wr_idx_i] <= fill_line_i;
        end else if (merge_en_i) begin
            mem_q[wr_idx_i][int'(merge_wsel_i)*WORD_W +: WORD_W] <= merge_word_i;
        end
    end

    assign rd_line_o = mem_q[rd_idx_i];

endmodule

// File: rtl/dcache_sa_top.sv
// Set-associative write-back/write-allocate L1 data cache with true-LRU (tree PLRU at 4 ways).
// Define DCACHE_STATS_EN to add saturating hit/miss/writeback counters.
module dcache_sa_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       stat_hit_o,
    output logic [31:0]       stat_miss_o,
    output logic [31:0]       stat_wb_o,
`endif
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o
);

    localparam int OFF_W     = $clog2(LINE_W / 8);
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_BITS  = ADDR_W - OFF_W - IDX_W;
    localparam int BSEL_W    = $clog2(WORD_W / 8);
    localparam int WS_W      = $clog2(LINE_W / WORD_W);
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e              state_q, state_d;
    tag_entry_t          tags_q [WAYS][SETS];
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic                mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   rdata_q;

    logic [IDX_W-1:0]    p1_idx, rd_idx, wr_idx;
    logic [TAG_BITS-1:0] p1_tag;
    logic [WS_W-1:0]     p1_wsel;
    logic                unused_byte_bits;
    logic                req, hit, access_ok, hit_touch, store_hit, refill_we;
    logic [WAYS-1:0]     hit_vec;
    logic [WAY_W-1:0]    hit_way, lru_way, victim_c;
    logic [LINE_W-1:0]   line_rd [WAYS];
    logic [LINE_W-1:0]   hit_line;
    logic [WORD_W-1:0]   hit_word;
    tag_entry_t          vic_e;

    assign p1_idx           = p1_addr_i[OFF_W +: IDX_W];
    assign p1_tag           = p1_addr_i[ADDR_W-1 -: TAG_BITS];
    assign p1_wsel          = p1_addr_i[BSEL_W +: WS_W];
    assign unused_byte_bits = ^p1_addr_i[BSEL_W-1:0];

    assign req        = p1_MemRead_i | p1_MemWrite_i;
    assign access_ok  = (state_q == IDLE) || (state_q == REFILL_DONE);
    assign hit_touch  = access_ok & req & hit;
    assign store_hit  = hit_touch & p1_MemWrite_i;
    assign refill_we  = (state_q == REFILL) & mem_ack_i;
    assign rd_idx     = access_ok ? p1_idx : idx_q;
    assign wr_idx     = refill_we ? idx_q : p1_idx;
    assign vic_e      = tags_q[victim_q][idx_q];

    always_comb begin
        hit_way  = '0;
        victim_c = lru_way;
        hit_line = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = tags_q[w][p1_idx].valid && (tags_q[w][p1_idx].tag[TAG_BITS-1:0] == p1_tag);
            if (hit_vec[w]) begin
                hit_way  = WAY_W'(w);
                hit_line = line_rd[w];
            end
            if (!tags_q[w][p1_idx].valid) victim_c = WAY_W'(w);
        end
    end

    assign hit        = |hit_vec;
    assign hit_word   = hit_line[int'(p1_wsel)*WORD_W +: WORD_W];
    assign p1_data_o  = hit ? hit_word : rdata_q;
    assign p1_stall_o = req & ~hit;

    assign mem_data_o   = line_rd[victim_q];
    assign mem_addr_o   = mem_addr_q;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way #(.SETS(SETS), .LINE_W(LINE_W), .WORD_W(WORD_W)) u_way (
            .clk_i        (clk_i),
            .rd_idx_i     (rd_idx),
            .rd_line_o    (line_rd[w]),
            .wr_idx_i     (wr_idx),
            .fill_en_i    (refill_we && (victim_q == WAY_W'(w))),
            .fill_line_i  (mem_data_i),
            .merge_en_i   (store_hit && hit_vec[w]),
            .merge_wsel_i (p1_wsel),
            .merge_word_i (p1_data_i)
        );
    end

    // Replacement state: lru_way names the way to evict in the currently addressed set.
    if (WAYS == 2) begin : g_lru2
        logic lru_q [SETS];
        assign lru_way = lru_q[p1_idx];
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
            end else if (refill_we) begin
                lru_q[idx_q] <= ~victim_q[0];
            end else if (hit_touch) begin
                lru_q[p1_idx] <= ~hit_way[0];
            end
        end
    end else if (WAYS == 4) begin : g_lru4
        logic [2:0] plru_q [SETS];
        assign lru_way = plru4_victim(plru_q[p1_idx]);
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                for (int s = 0; s < SETS; s++) plru_q[s] <= 3'b000;
            end else if (refill_we) begin
                plru_q[idx_q] <= plru4_touch(plru_q[idx_q], 2'(victim_q));
            end else if (hit_touch) begin
                plru_q[p1_idx] <= plru4_touch(plru_q[p1_idx], 2'(hit_way));
            end
        end
    end else begin : g_lru1
        assign lru_way = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    tags_q[w][s] <= '0;
        end else if (refill_we) begin
            tags_q[victim_q][idx_q] <= '{valid: 1'b1, dirty: 1'b0, tag: ADDR_W_MAX'(tag_q)};
        end else if (store_hit) begin
            tags_q[hit_way][p1_idx].dirty <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            victim_q   <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            victim_q   <= victim_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            if (hit) rdata_q <= hit_word;
        end
    end

    // Victim, index and tag are captured on the IDLE->MISS edge and drive the whole miss.
    always_comb begin
        state_d    = state_q;
        mem_en_d   = mem_en_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        victim_d   = victim_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d  = MISS;
                    victim_d = victim_c;
                    idx_d    = p1_idx;
                    tag_d    = p1_tag;
                end
            end
            MISS: begin
                mem_en_d = 1'b1;
                if (vic_e.valid && vic_e.dirty) begin
                    state_d    = WRITEBACK;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = {vic_e.tag[TAG_BITS-1:0], idx_q, {OFF_W{1'b0}}};
                end else begin
                    state_d    = REFILL;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {tag_q, idx_q, {OFF_W{1'b0}}};
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d    = REFILL;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {tag_q, idx_q, {OFF_W{1'b0}}};
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_d  = REFILL_DONE;
                    mem_en_d = 1'b0;
                end
            end
            REFILL_DONE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && req && hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (state_q == IDLE && req && !hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (state_q == MISS && vic_e.valid && vic_e.dirty && wb_cnt_q != '1)
                wb_cnt_q <= wb_cnt_q + 1'b1;
        end
    end

    assign stat_hit_o  = hit_cnt_q;
    assign stat_miss_o = miss_cnt_q;
    assign stat_wb_o   = wb_cnt_q;
`endif

    assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(hit_vec));

endmodule
